dyn_led_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for an 8-digit common-segment seven-segment display.
- Holds one value per digit and drives one digit at a time, with a blanking gap between digits to suppress ghosting.
- Host writes land in shadow registers and are committed to the display only at frame boundaries, so the display never tears.
- Sits between the hex-to-segment decode path and the board digit/segment pins; replaces a static single-digit drive.

---
 rtl/dyn_led_pkg.sv | 22 ++
 rtl/dyn_led_hex7seg.sv | 28 ++
 rtl/dyn_led_scan_ctrl.sv | 93 +++++++++
 tb/tb_dyn_led_scan_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/dyn_led_pkg.sv
// dyn_led_pkg: segment codes, digit type and scan FSM states shared by the scan controller.
package dyn_led_pkg;
  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;
  typedef logic [4:0] digit_t;
  typedef enum logic {ST_BLANK, ST_SHOW} state_t;
endpackage

// File: rtl/dyn_led_hex7seg.sv
// hex7seg: combinational hex nibble to 7-segment (.gfedcba, active-high) lookup.
module hex7seg
  import dyn_led_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end
endmodule

// File: rtl/dyn_led_scan_ctrl.sv
// dyn_led_scan_ctrl: multiplexed seven-segment scanner with blanking gap and frame-synchronous shadow commit.
// Define DYN_SCAN_LZB_EN to dark leading zero digits (digit NUM_DIG-1 most significant).
module dyn_led_scan_ctrl
  import dyn_led_pkg::*;
#(
  parameter int NUM_DIG   = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               wrValid,
  output logic               wrReady,
  input  logic [2:0]         wrAddr,
  input  logic [4:0]         wrData,
  input  logic [NUM_DIG-1:0] digEn,
  output logic [7:0]         segOut,
  output logic [NUM_DIG-1:0] digOut,
  output logic               frameDone
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIG);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIG - 1);
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  digit_t             shadow_q [NUM_DIG];
  digit_t             shadow_d [NUM_DIG];
  digit_t             active_q [NUM_DIG];
  digit_t             active_d [NUM_DIG];
  logic [7:0]         seg_q, seg_d;
  logic [NUM_DIG-1:0] dig_q, dig_d;
  logic               done_q, done_d;
  logic               wrap, commit, wr_acc, show;
  digit_t             cur;
  logic [6:0]         cur_seg;
  assign wrap    = cnt_q == CNT_LAST;
  assign commit  = wrap && idx_q == IDX_LAST;
  assign wrReady = !rst && !commit;
  assign wr_acc  = wrValid && wrReady;
  assign cur     = active_q[idx_q];
  hex7seg u_dec (.hex(cur[3:0]), .seg(cur_seg));
`ifdef DYN_SCAN_LZB_EN
  logic [NUM_DIG-1:0] lz;
  always_comb begin
    lz = '0;
    lz[NUM_DIG-1] = active_q[NUM_DIG-1] == '0;
    for (int i = NUM_DIG - 2; i >= 0; i--) lz[i] = lz[i+1] && active_q[i] == '0;
  end
  assign show = state_q == ST_SHOW && digEn[idx_q] && (idx_q == '0 || !lz[idx_q]);
`else
  assign show = state_q == ST_SHOW && digEn[idx_q];
`endif
  always_comb begin
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    idx_d   = wrap ? (idx_q == IDX_LAST ? '0 : idx_q + 1'b1) : idx_q;
    state_d = state_q == ST_BLANK ? (cnt_q == BLK_LAST ? ST_SHOW : ST_BLANK)
                                  : (wrap ? ST_BLANK : ST_SHOW);
    seg_d   = show ? {cur[4], cur_seg} : SEG_OFF;
    dig_d   = show ? ~(NUM_DIG'(1) << idx_q) : '1;
    done_d  = commit;
    for (int i = 0; i < NUM_DIG; i++) begin
      shadow_d[i] = (wr_acc && int'(wrAddr) == i) ? wrData : shadow_q[i];
      active_d[i] = commit ? shadow_q[i] : active_q[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_BLANK;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      seg_q    <= SEG_OFF;
      dig_q    <= '1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      done_q   <= done_d;
    end
  end
  assign segOut    = seg_q;
  assign digOut    = dig_q;
  assign frameDone = done_q;
endmodule

// File: tb/tb_dyn_led_scan_ctrl.sv
// tb_dyn_led_scan_ctrl: scoreboard bench, predicted outputs queued one cycle ahead and popped at each negedge.
module tb_dyn_led_scan_ctrl;
  localparam int ND = 4, SD = 8, BC = 2, FR = ND * SD;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic clk = 0, rst = 1, wr_valid = 0, rst_edge = 0;
  logic [2:0] wr_addr = '0;
  logic [4:0] wr_data = '0;
  logic [ND-1:0] dig_en = '1;
  logic wr_ready, frame_done;
  logic [7:0] seg_out;
  logic [ND-1:0] dig_out;
  int n_cmp = 0, n_err = 0, t = 0;
  logic [4:0] sh [ND];
  logic [4:0] act [ND];
  logic [11:0] exp_q [$];
  always #5 clk = ~clk;
  dyn_led_scan_ctrl #(.NUM_DIG(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .wrValid(wr_valid), .wrReady(wr_ready), .wrAddr(wr_addr),
    .wrData(wr_data), .digEn(dig_en), .segOut(seg_out), .digOut(dig_out), .frameDone(frame_done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask
  always @(posedge clk) rst_edge <= rst;
  initial begin
    int p, s;
    logic show, lz;
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rdy_in_rst", wr_ready, 0);
        if (rst_edge) begin
          check("seg_rst", seg_out, 8'h00);
          check("dig_rst", dig_out, 4'hF);
          check("fd_rst", frame_done, 0);
        end
        t = 0;
        for (int i = 0; i < ND; i++) begin
          sh[i] = '0;
          act[i] = '0;
        end
        exp_q.delete();
        exp_q.push_back({8'h00, 4'hF});
      end else begin
        if (exp_q.size() == 0) check("q_empty", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("seg", seg_out, e[11:4]);
          check("dig", dig_out, e[3:0]);
        end
        check("rdy", wr_ready, (t % FR) != FR - 1);
        check("fd", frame_done, t > 0 && t % FR == 0);
        p = t % SD;
        s = (t / SD) % ND;
        show = p >= BC && dig_en[s];
        lz = 0;
`ifdef DYN_SCAN_LZB_EN
        lz = s > 0;
        for (int j = s; j < ND; j++) if (act[j] != 0) lz = 0;
`endif
        if (show && !lz) exp_q.push_back({act[s][4], HEX[act[s][3:0]], ~(4'b0001 << s)});
        else exp_q.push_back({8'h00, 4'hF});
        if (wr_valid && (t % FR) != FR - 1 && wr_addr < ND) sh[wr_addr[1:0]] = wr_data;
        if (t % FR == FR - 1) for (int i = 0; i < ND; i++) act[i] = sh[i];
        t++;
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [4:0] d, output int waits);
    waits = 0;
    wr_valid = 1;
    wr_addr = a;
    wr_data = d;
    while (!wr_ready && waits < 100) begin
      cyc(1);
      waits++;
    end
    check("wr_accept", wr_ready, 1);
    cyc(1);
    wr_valid = 0;
  endtask
  task automatic wait_until(input int ph);
    for (int k = 0; k < FR && t % FR != ph; k++) cyc(1);
    check("sync", t % FR, ph);
  endtask
  initial begin
    int w;
    cyc(3);
    rst = 0;
    cyc(10);
    wr(1, 5'h05, w);
    wait_until(FR - 1);
    wr(2, 5'h1A, w);
    check("hold_wait", w, 1);
    wr(6, 5'h1F, w);
    cyc(FR * 2);
    dig_en = 4'b0101;
    cyc(FR * 2);
    dig_en = 4'b1111;
    wr(3, 5'h00, w);
    wr(2, 5'h00, w);
    wr(1, 5'h03, w);
    wr(0, 5'h00, w);
    cyc(FR * 2 + 5);
    wr(0, 5'h08, w);
    cyc(3);
    rst = 1;
    cyc(2);
    rst = 0;
    cyc(FR * 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
